anita3_event_header_reader: RTL and testbench
=============================================

ANITA3_EVENT_HEADER_READER -- requirements
Module: anita3_event_header_reader

Interface
REQ-001 Parameter HEADER_WORDS, default 22: header words streamed per event, offsets 0x00..HEADER_WORDS-1; legal range 1..64.
REQ-002 clk33_i  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_i  input  1  reset: synchronous, active-high.
REQ-004 event_addr_i  input  8  [7:6] buffer index 0..3, [5:0] header word offset.
REQ-005 event_dat_i  input  16  header word to store.
REQ-006 event_wr_i  input  1  write strobe; may be held high for many cycles, and the last value per address wins.
REQ-007 event_done_i  input  1  one-cycle pulse marking the buffer in event_addr_i[7:6] complete; may coincide with a write.
REQ-008 rd_dat_o  output  16  header word being presented.
REQ-009 rd_valid_o  output  1  rd_dat_o valid.
REQ-010 rd_ready_i  input  1  consumer accepts a word when rd_valid_o and rd_ready_i are both high.
REQ-011 rd_last_o  output  1  presented word is offset HEADER_WORDS-1.
REQ-012 rd_buffer_o  output  2  buffer index currently being streamed.
REQ-013 buf_pending_o  output  4  one bit per buffer: completed and not yet fully read.
REQ-014 err_clr_i  input  1  clears the sticky error flags.
REQ-015 overflow_o  output  1  sticky: done received for a buffer already pending.
REQ-016 collision_o  output  1  sticky: write received to a pending buffer.

Function
REQ-017 Storage: 4 x 64 x 16 RAM, write address {event_addr_i}; a write is performed when event_wr_i=1 and buf_pending_o[event_addr_i[7:6]]=0.
REQ-018 A write to a pending buffer is dropped and sets collision_o the next cycle.
REQ-019 A done for a non-pending buffer sets that pending bit and enqueues the index into a 4-entry FIFO; any write in the same cycle is stored first.
REQ-020 A done for an already-pending buffer sets overflow_o and leaves the queue and bits unchanged.
REQ-021 Readout order is the completion order (queue order), not buffer number.
REQ-022 FSM states and transitions: IDLE -> FETCH when queue is non-empty (pop the index and latch it into rd_buffer_o, offset=0). FETCH -> PRESENT (RAM read latency is 1 cycle). PRESENT holds until accept; on accept, if offset<HEADER_WORDS-1 then offset+1 and go to FETCH, else go to RELEASE. RELEASE clears the pending bit of rd_buffer_o and goes to IDLE.
REQ-023 rd_valid_o=1 only in PRESENT; rd_dat_o and rd_last_o are registered and stable while valid is high and not accepted.
REQ-024 Throughput is 1 word per 2 cycles; the first rd_valid_o comes 2 cycles after the queue becomes non-empty in IDLE.
REQ-025 Enqueue and dequeue in the same cycle are both honoured, and the count is unchanged.
REQ-026 The queue cannot overflow because it holds at most one entry per buffer; the pending bits guarantee this.
REQ-027 A done for rd_buffer_o during RELEASE counts as pending, so it sets overflow_o.
REQ-028 err_clr_i clears both flags; a new error in the same cycle wins.
REQ-029 The offset counter is 6 bits and compares against HEADER_WORDS-1; it does not wrap.

Reset
REQ-030 On rst_i: FSM=IDLE, queue empty, buf_pending_o=0, rd_valid_o=0, rd_last_o=0, rd_dat_o=0, rd_buffer_o=0, overflow_o=0, collision_o=0.
REQ-031 RAM contents are not reset.
REQ-032 A readout interrupted by reset is abandoned, and the buffer becomes non-pending.

Structure
REQ-033 Package anita3_evhdr_pkg holds: HEADER_WORDS default, the FSM state encoding (IDLE, FETCH, PRESENT, RELEASE), the buffer-index width (2) and the offset width (6).
REQ-034 Sub-module anita3_evhdr_ram: simple dual-port 256x16 RAM, one write port, one read port with registered 1-cycle read; the FIFO and FSM stay in the top.

Verification
REQ-035 Basic readout: write buffer 2 offsets 0x00..0x15 with data 0x2000+offset, done on buffer 2, rd_ready_i=1 -> 22 words 0x2000..0x2015; rd_buffer_o=2; rd_last_o only on 0x2015; buf_pending_o goes 0100 -> 0000.
REQ-036 Held strobe: event_wr_i held 5 cycles at address 0x10 with data 0x0001..0x0005 -> word 0x10 reads 0x0005.
REQ-037 Coincident write and done: write offset 0x00 = 0xBEEF in the same cycle as done on buffer 1 -> first word read is 0xBEEF; collision_o stays 0.
REQ-038 Completion order: done on buffer 3, then 0, then 1 -> readouts in order 3, 0, 1.
REQ-039 Back-pressure: rd_ready_i low for 10 cycles on word 5 -> rd_dat_o and rd_valid_o stable throughout; no word skipped.
REQ-040 Errors and reset: a second done on pending buffer 0 -> overflow_o=1; a write to buffer 0 -> collision_o=1, stored data unchanged; err_clr_i -> both 0; rst_i mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/anita3_evhdr_pkg.sv
// Shared constants and FSM encoding for the ANITA3 event header reader.
package anita3_evhdr_pkg;

   localparam int unsigned HEADER_WORDS_DEF = 22;
   localparam int unsigned BUF_W            = 2;
   localparam int unsigned OFS_W            = 6;
   localparam int unsigned ADDR_W           = BUF_W + OFS_W;
   localparam int unsigned QUEUE_DEPTH      = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      RELEASE = 2'd3
   } evhdr_state_t;

endpackage

// File: rtl/anita3_evhdr_ram.sv
// 256x16 simple dual-port header store: one write port, registered read port.
module anita3_evhdr_ram
   import anita3_evhdr_pkg::*;
(
   input  logic              clk33_i,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_dat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_dat
);

   logic [15:0] mem [2**ADDR_W];

   always_ff @(posedge clk33_i) begin
      if (wr_en)
         mem[wr_addr] <= wr_dat;
      rd_dat <= mem[rd_addr];
   end

endmodule

// File: rtl/anita3_event_header_reader.sv
// Collects event headers into four buffers and streams completed buffers
// out in completion order over a valid/ready interface.
module anita3_event_header_reader
   import anita3_evhdr_pkg::*;
#(
   parameter int unsigned HEADER_WORDS = HEADER_WORDS_DEF
) (
   input  logic             clk33_i,
   input  logic             rst_i,
   input  logic [7:0]       event_addr_i,
   input  logic [15:0]      event_dat_i,
   input  logic             event_wr_i,
   input  logic             event_done_i,
   output logic [15:0]      rd_dat_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic             rd_last_o,
   output logic [BUF_W-1:0] rd_buffer_o,
   output logic [3:0]       buf_pending_o,
   input  logic             err_clr_i,
   output logic             overflow_o,
   output logic             collision_o
);

   localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(HEADER_WORDS - 1);

   evhdr_state_t     state;
   logic [OFS_W-1:0] offset;
   logic [BUF_W-1:0] ev_buf;
   logic             ev_pending;
   logic             wr_en;
   logic             enq;
   logic             deq;
   logic             accept;
   logic             last_ofs;
   logic [3:0]       pend_nxt;
   logic [ADDR_W-1:0] ram_raddr;
   logic [15:0]      ram_rdat;

   logic [BUF_W-1:0] fifo_q [QUEUE_DEPTH];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [2:0]       count;

   assign ev_buf     = event_addr_i[7:6];
   assign ev_pending = buf_pending_o[ev_buf];
   assign wr_en      = event_wr_i & ~ev_pending;
   assign enq        = event_done_i & ~ev_pending;
   assign deq        = (state == IDLE) && (count != 3'd0);
   assign accept     = (state == PRESENT) && rd_ready_i;
   assign last_ofs   = (offset == LAST_OFS);

   // Read address looks one state ahead so the RAM word is ready in FETCH
   // and can be registered straight into rd_dat_o on entry to PRESENT.
   always_comb begin
      ram_raddr = {rd_buffer_o, offset};
      if (deq)
         ram_raddr = {fifo_q[rd_ptr], {OFS_W{1'b0}}};
      else if (accept && !last_ofs)
         ram_raddr = {rd_buffer_o, offset + 6'd1};
   end

   always_comb begin
      pend_nxt = buf_pending_o;
      if (enq)
         pend_nxt[ev_buf] = 1'b1;
      if (state == RELEASE)
         pend_nxt[rd_buffer_o] = 1'b0;
   end

   anita3_evhdr_ram u_ram (
      .clk33_i (clk33_i),
      .wr_en   (wr_en),
      .wr_addr (event_addr_i),
      .wr_dat  (event_dat_i),
      .rd_addr (ram_raddr),
      .rd_dat  (ram_rdat)
   );

   always_ff @(posedge clk33_i) begin
      if (rst_i) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         buf_pending_o <= '0;
         overflow_o    <= 1'b0;
         collision_o   <= 1'b0;
      end else begin
         buf_pending_o <= pend_nxt;
         if (enq) begin
            fifo_q[wr_ptr] <= ev_buf;
            wr_ptr         <= wr_ptr + 2'd1;
         end
         if (deq)
            rd_ptr <= rd_ptr + 2'd1;
         case ({enq, deq})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         if (event_done_i && ev_pending)
            overflow_o <= 1'b1;
         else if (err_clr_i)
            overflow_o <= 1'b0;
         if (event_wr_i && ev_pending)
            collision_o <= 1'b1;
         else if (err_clr_i)
            collision_o <= 1'b0;
      end
   end

   always_ff @(posedge clk33_i) begin
      if (rst_i) begin
         state       <= IDLE;
         offset      <= '0;
         rd_buffer_o <= '0;
         rd_dat_o    <= '0;
         rd_valid_o  <= 1'b0;
         rd_last_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rd_valid_o <= 1'b0;
               if (deq) begin
                  rd_buffer_o <= fifo_q[rd_ptr];
                  offset      <= '0;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               rd_dat_o   <= ram_rdat;
               rd_last_o  <= last_ofs;
               rd_valid_o <= 1'b1;
               state      <= PRESENT;
            end
            PRESENT: begin
               if (rd_ready_i) begin
                  rd_valid_o <= 1'b0;
                  if (!last_ofs) begin
                     offset <= offset + 6'd1;
                     state  <= FETCH;
                  end else begin
                     state <= RELEASE;
                  end
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_anita3_event_header_reader.sv
// Scoreboard bench for the event header reader: directed writes/dones,
// monitor checks every accepted word and hold stability under back-pressure.
module tb_anita3_event_header_reader;

   logic        clk33_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  event_addr_i = '0;
   logic [15:0] event_dat_i = '0;
   logic        event_wr_i = 1'b0;
   logic        event_done_i = 1'b0;
   logic [15:0] rd_dat_o;
   logic        rd_valid_o;
   logic        rd_ready_i = 1'b0;
   logic        rd_last_o;
   logic [1:0]  rd_buffer_o;
   logic [3:0]  buf_pending_o;
   logic        err_clr_i = 1'b0;
   logic        overflow_o;
   logic        collision_o;

   typedef struct packed {
      logic [1:0]  b;
      logic [15:0] d;
      logic        l;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   logic ready_en = 1'b1;
   int   stall_cnt = 0;
   logic        prev_v = 1'b0;
   logic        prev_r = 1'b0;
   logic [15:0] prev_d = '0;

   anita3_event_header_reader #(.HEADER_WORDS(22)) dut (
      .clk33_i       (clk33_i),
      .rst_i         (rst_i),
      .event_addr_i  (event_addr_i),
      .event_dat_i   (event_dat_i),
      .event_wr_i    (event_wr_i),
      .event_done_i  (event_done_i),
      .rd_dat_o      (rd_dat_o),
      .rd_valid_o    (rd_valid_o),
      .rd_ready_i    (rd_ready_i),
      .rd_last_o     (rd_last_o),
      .rd_buffer_o   (rd_buffer_o),
      .buf_pending_o (buf_pending_o),
      .err_clr_i     (err_clr_i),
      .overflow_o    (overflow_o),
      .collision_o   (collision_o)
   );

   always #5 clk33_i = ~clk33_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Consumer: stalls 10 cycles on word 0x3305, otherwise follows ready_en.
   always @(posedge clk33_i) begin
      #1;
      if (rd_valid_o && rd_dat_o == 16'h3305 && stall_cnt < 10) begin
         rd_ready_i = 1'b0;
         stall_cnt++;
      end else begin
         rd_ready_i = ready_en;
      end
   end

   always @(negedge clk33_i) begin
      exp_t e;
      if (!rst_i) begin
         if (prev_v && !prev_r) begin
            chk("hold_valid", {31'd0, rd_valid_o}, 32'd1);
            chk("hold_dat", {16'd0, rd_dat_o}, {16'd0, prev_d});
         end
         if (rd_valid_o && rd_ready_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %h, expected none", rd_dat_o);
            end else begin
               e = exp_q.pop_front();
               chk("rd_dat", {16'd0, rd_dat_o}, {16'd0, e.d});
               chk("rd_last", {31'd0, rd_last_o}, {31'd0, e.l});
               chk("rd_buffer", {30'd0, rd_buffer_o}, {30'd0, e.b});
            end
         end
      end
      prev_v = rd_valid_o;
      prev_r = rd_ready_i;
      prev_d = rd_dat_o;
   end

   task automatic tick();
      @(posedge clk33_i);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      event_addr_i = a;
      event_dat_i  = d;
      event_wr_i   = 1'b1;
      tick();
      event_wr_i   = 1'b0;
   endtask

   task automatic done(input logic [1:0] b);
      event_addr_i = {b, 6'h00};
      event_done_i = 1'b1;
      tick();
      event_done_i = 1'b0;
   endtask

   task automatic fill(input logic [1:0] b, input logic [15:0] base, input int first);
      for (int o = first; o < 22; o++)
         wr({b, 6'(o)}, base + 16'(o));
   endtask

   task automatic push_buf(input logic [1:0] b, input logic [15:0] base,
                           input int ovr_ofs, input logic [15:0] ovr_dat);
      exp_t e;
      for (int o = 0; o < 22; o++) begin
         e.b = b;
         e.d = (o == ovr_ofs) ? ovr_dat : base + 16'(o);
         e.l = (o == 21);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400 && !(exp_q.size() == 0 && buf_pending_o == 4'b0000); i++)
         tick();
      chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_pending"}, {28'd0, buf_pending_o}, 32'd0);
   endtask

   initial begin
      tick();
      tick();
      rst_i = 1'b0;
      chk("rst_valid", {31'd0, rd_valid_o}, 32'd0);
      chk("rst_dat", {16'd0, rd_dat_o}, 32'd0);
      chk("rst_last", {31'd0, rd_last_o}, 32'd0);
      chk("rst_buffer", {30'd0, rd_buffer_o}, 32'd0);
      chk("rst_pending", {28'd0, buf_pending_o}, 32'd0);
      chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
      chk("rst_col", {31'd0, collision_o}, 32'd0);

      // Basic readout of buffer 2 with latency check
      fill(2'd2, 16'h2000, 0);
      push_buf(2'd2, 16'h2000, 63, 16'h0000);
      done(2'd2);
      chk("basic_pending", {28'd0, buf_pending_o}, 32'h4);
      chk("lat_valid0", {31'd0, rd_valid_o}, 32'd0);
      tick();
      chk("lat_valid1", {31'd0, rd_valid_o}, 32'd0);
      tick();
      chk("lat_valid2", {31'd0, rd_valid_o}, 32'd1);
      wait_drain("basic");

      // Held write strobe: last value wins
      fill(2'd0, 16'h0A00, 0);
      event_addr_i = 8'h10;
      event_wr_i   = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         event_dat_i = 16'(k);
         tick();
      end
      event_wr_i = 1'b0;
      push_buf(2'd0, 16'h0A00, 16, 16'h0005);
      done(2'd0);
      wait_drain("held");

      // Write coinciding with done on buffer 1
      fill(2'd1, 16'h1100, 1);
      push_buf(2'd1, 16'h1100, 0, 16'hBEEF);
      event_addr_i = 8'h40;
      event_dat_i  = 16'hBEEF;
      event_wr_i   = 1'b1;
      event_done_i = 1'b1;
      tick();
      event_wr_i   = 1'b0;
      event_done_i = 1'b0;
      chk("coinc_col", {31'd0, collision_o}, 32'd0);
      chk("coinc_pending", {28'd0, buf_pending_o}, 32'h2);
      wait_drain("coinc");

      // Completion order 3,0,1 with consumer stalled, then errors
      ready_en = 1'b0;
      fill(2'd3, 16'h3300, 0);
      fill(2'd0, 16'h0300, 0);
      fill(2'd1, 16'h1300, 0);
      push_buf(2'd3, 16'h3300, 63, 16'h0000);
      push_buf(2'd0, 16'h0300, 63, 16'h0000);
      push_buf(2'd1, 16'h1300, 63, 16'h0000);
      done(2'd3);
      done(2'd0);
      done(2'd1);
      chk("order_pending", {28'd0, buf_pending_o}, 32'hB);
      chk("order_ovf0", {31'd0, overflow_o}, 32'd0);
      done(2'd0);
      chk("ovf_set", {31'd0, overflow_o}, 32'd1);
      chk("ovf_pending", {28'd0, buf_pending_o}, 32'hB);
      wr(8'h05, 16'hDEAD);
      chk("col_set", {31'd0, collision_o}, 32'd1);
      err_clr_i    = 1'b1;
      event_addr_i = 8'h06;
      event_wr_i   = 1'b1;
      tick();
      event_wr_i   = 1'b0;
      chk("clr_newcol", {31'd0, collision_o}, 32'd1);
      chk("clr_ovf", {31'd0, overflow_o}, 32'd0);
      tick();
      err_clr_i = 1'b0;
      chk("clr_col", {31'd0, collision_o}, 32'd0);
      chk("clr_ovf2", {31'd0, overflow_o}, 32'd0);
      ready_en = 1'b1;
      wait_drain("order");
      chk("stall_seen", 32'(stall_cnt), 32'd10);

      // Reset in the middle of a readout
      push_buf(2'd2, 16'h2000, 63, 16'h0000);
      done(2'd2);
      done(2'd2);
      chk("pre_rst_ovf", {31'd0, overflow_o}, 32'd1);
      for (int i = 0; i < 100 && !(rd_valid_o && rd_dat_o == 16'h2003); i++)
         tick();
      chk("pre_rst_word", {16'd0, rd_dat_o}, 32'h2003);
      rst_i = 1'b1;
      tick();
      chk("mid_rst_valid", {31'd0, rd_valid_o}, 32'd0);
      chk("mid_rst_dat", {16'd0, rd_dat_o}, 32'd0);
      chk("mid_rst_last", {31'd0, rd_last_o}, 32'd0);
      chk("mid_rst_buffer", {30'd0, rd_buffer_o}, 32'd0);
      chk("mid_rst_pending", {28'd0, buf_pending_o}, 32'd0);
      chk("mid_rst_ovf", {31'd0, overflow_o}, 32'd0);
      rst_i = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 6; i++)
         tick();
      chk("post_rst_valid", {31'd0, rd_valid_o}, 32'd0);
      chk("post_rst_pending", {28'd0, buf_pending_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
